// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops bytes from the TX FIFO and drives the UART line.
// Frame = start, 5..8 data bits LSB first, optional parity, 1 or 2 stops.
//
// Ports:
//   clk, rst_n        core clock, async active-low reset
//   cfg_i[7:0]        {baud[7:5], stop[4], parity[3:2], width[1:0]}
//   tx_data_i[7:0]    byte to send, taken on valid & ready
//   tx_data_valid_i   FIFO not empty
//   tx_data_ready_o   high while idle (and out of reset)
//   TX                serial line, idle high
//   busy_o            frame (or break) in progress
//   frame_done_o      one-cycle pulse on return to idle after a frame
//   tx_break_i        only with UART_TX_BREAK_EN: hold line low
//
// Optional feature macro: UART_TX_BREAK_EN (line break generation).

module uart_tx_serializer #(
  parameter int INTERNAL_CLOCK = 1_000_000,
  parameter int BAUD_CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] cfg_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_data_valid_i,
`ifdef UART_TX_BREAK_EN
  input  logic       tx_break_i,
`endif
  output logic       tx_data_ready_o,
  output logic       TX,
  output logic       busy_o,
  output logic       frame_done_o
);

  function automatic int f_div(input int baud);
    int d;
    d = INTERNAL_CLOCK / baud;
    if (d < 1) d = 1;
    return d;
  endfunction

  localparam int DIV0 = f_div(4800);
  localparam int DIV1 = f_div(9600);
  localparam int DIV2 = f_div(19200);
  localparam int DIV3 = f_div(38400);
  localparam int DIV4 = f_div(57600);
  localparam int DIV5 = f_div(115200);
  localparam int DIV6 = f_div(230400);
  localparam int DIV7 = f_div(460800);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
`ifdef UART_TX_BREAK_EN
    ,
    S_BREAK,
    S_BRK_END
`endif
  } state_t;

  state_t                r_state;
  logic [BAUD_CNT_W-1:0] r_cnt;
  logic [2:0]            r_baud;
  logic [1:0]            r_width;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  r_stop;
  logic                  r_stop_idx;
  logic [2:0]            r_bit_idx;
  logic [7:0]            r_shift;
  logic                  r_tx;
  logic                  r_busy;
  logic                  r_done;

  logic [BAUD_CNT_W-1:0] w_div;
  logic                  w_last;
  logic                  w_last_bit;
  logic [7:0]            w_mask;
  logic                  w_par_even;
  logic                  w_par_en;

  always_comb begin
    w_div = BAUD_CNT_W'(DIV0);
    unique case (r_baud)
      3'd0: w_div = BAUD_CNT_W'(DIV0);
      3'd1: w_div = BAUD_CNT_W'(DIV1);
      3'd2: w_div = BAUD_CNT_W'(DIV2);
      3'd3: w_div = BAUD_CNT_W'(DIV3);
      3'd4: w_div = BAUD_CNT_W'(DIV4);
      3'd5: w_div = BAUD_CNT_W'(DIV5);
      3'd6: w_div = BAUD_CNT_W'(DIV6);
      3'd7: w_div = BAUD_CNT_W'(DIV7);
      default: w_div = BAUD_CNT_W'(DIV0);
    endcase
  end

  always_comb begin
    w_mask = 8'hFF;
    unique case (cfg_i[1:0])
      2'd0: w_mask = 8'h1F;
      2'd1: w_mask = 8'h3F;
      2'd2: w_mask = 8'h7F;
      2'd3: w_mask = 8'hFF;
      default: w_mask = 8'hFF;
    endcase
  end

  assign w_last     = (r_cnt == w_div - BAUD_CNT_W'(1));
  // last data bit index is N-1 = 4 + width
  assign w_last_bit = (r_bit_idx == {1'b1, r_width});
  assign w_par_even = ^(tx_data_i & w_mask);
  // codes 1 (odd) and 2 (even) enable parity; 0 and 3 do not
  assign w_par_en   = cfg_i[3] ^ cfg_i[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_baud     <= 3'd0;
      r_width    <= 2'd0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop     <= 1'b0;
      r_stop_idx <= 1'b0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'h00;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
`ifdef UART_TX_BREAK_EN
          if (tx_break_i) begin
            r_state <= S_BREAK;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
          end else
`endif
          if (tx_data_valid_i) begin
            r_state   <= S_START;
            r_tx      <= 1'b0;
            r_busy    <= 1'b1;
            r_shift   <= tx_data_i;
            r_baud    <= cfg_i[7:5];
            r_stop    <= cfg_i[4];
            r_width   <= cfg_i[1:0];
            r_par_en  <= w_par_en;
            // code 1 is odd parity: invert the even result
            r_par_bit <= cfg_i[2] ? ~w_par_even : w_par_even;
          end
        end

        S_START: begin
          if (w_last) begin
            r_cnt     <= '0;
            r_state   <= S_DATA;
            r_tx      <= r_shift[0];
            r_bit_idx <= 3'd0;
          end else begin
            r_cnt <= r_cnt + BAUD_CNT_W'(1);
          end
        end

        S_DATA: begin
          if (w_last) begin
            r_cnt <= '0;
            if (w_last_bit) begin
              if (r_par_en) begin
                r_state <= S_PARITY;
                r_tx    <= r_par_bit;
              end else begin
                r_state    <= S_STOP;
                r_tx       <= 1'b1;
                r_stop_idx <= 1'b0;
              end
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + BAUD_CNT_W'(1);
          end
        end

        S_PARITY: begin
          if (w_last) begin
            r_cnt      <= '0;
            r_state    <= S_STOP;
            r_tx       <= 1'b1;
            r_stop_idx <= 1'b0;
          end else begin
            r_cnt <= r_cnt + BAUD_CNT_W'(1);
          end
        end

        S_STOP: begin
          if (w_last) begin
            r_cnt <= '0;
            if (r_stop_idx == r_stop) begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_stop_idx <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + BAUD_CNT_W'(1);
          end
        end

`ifdef UART_TX_BREAK_EN
        S_BREAK: begin
          r_cnt <= '0;
          if (!tx_break_i) begin
            // recovery mark uses the baud selected at release time
            r_state <= S_BRK_END;
            r_tx    <= 1'b1;
            r_baud  <= cfg_i[7:5];
          end
        end

        S_BRK_END: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + BAUD_CNT_W'(1);
          end
        end
`endif

        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign tx_data_ready_o = rst_n & (r_state == S_IDLE);
  assign TX              = r_tx;
  assign busy_o          = r_busy;
  assign frame_done_o    = r_done;

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Downstream of the UART controller's TX FIFO: pops one byte per frame via valid/ready and drives the serial TX line.
- Builds start, data (LSB first), optional parity and stop bits from an 8-bit config byte.
- The config byte uses the same encoding as the controller's CONFIG.TX register, and is latched at frame start.
- Single clock domain. Bit timing comes from a clock divider derived from INTERNAL_CLOCK.

Parameters:
- INTERNAL_CLOCK, 1_000_000, core clock frequency in Hz.
- BAUD_CNT_W, 16, width of the bit-period counter; must hold INTERNAL_CLOCK/4800.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_i  in  8  config {baud[7:5], stop[4], parity[3:2], width[1:0]}.
- tx_data_i  in  8  byte to transmit.
- tx_data_valid_i  in  1  byte available (FIFO not empty).
- tx_data_ready_o  out  1  byte accepted this cycle when valid & ready.
- TX  out  1  serial line; idle high.
- busy_o  out  1  frame in progress.
- frame_done_o  out  1  one-cycle pulse when the last stop bit ends.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: TX=1, busy_o=0, frame_done_o=0, FSM=IDLE. tx_data_ready_o=1 once out of reset (it is 0 while rst_n=0).
- Asserting rst_n mid-frame aborts the frame immediately: TX returns to 1 asynchronously and the byte is discarded.
- Baud code to baud rate:
  - 0:4800, 1:9600, 2:19200, 3:38400
  - 4:57600, 5:115200, 6:230400, 7:460800
- Bit-period divider: DIV = INTERNAL_CLOCK/baud, truncated integer, with a floor of 1. Computed at elaboration as 8 constants, selected by the latched baud code.
- Width code: 0/1/2/3 gives 5/6/7/8 data bits. Only the low N bits of the byte are sent.
- Parity code:
  - 0: none
  - 1: odd (parity bit = ~^data[N-1:0])
  - 2: even (parity bit = ^data[N-1:0])
  - 3: reserved, treated as none
- Stop code: 0 gives 1 stop bit, 1 gives 2 stop bits.
- Handshake: tx_data_ready_o = (state==IDLE), registered-state based, with no combinational path from valid. A transfer occurs on a rising clk edge with valid & ready.
  - That edge latches tx_data_i and cfg_i.
  - The FSM enters START, so TX goes low in the next cycle.
- Config changes mid-frame are ignored until the next accepted byte.
- FSM states IDLE, START, DATA, PARITY, STOP. Each bit is held for exactly DIV cycles; the counter counts 0..DIV-1.
  - IDLE to START on handshake.
  - START to DATA after DIV cycles.
  - DATA shifts LSB first. After N bits it goes to PARITY if parity is 1 or 2, else to STOP.
  - PARITY to STOP after DIV cycles.
  - STOP lasts 1*DIV or 2*DIV cycles, then goes to IDLE and pulses frame_done_o in that same IDLE-entry cycle.
- busy_o=1 in all states except IDLE.
- Frame length in cycles = (1+N+P+S)*DIV, where P is 0 or 1 parity bits and S is 1 or 2 stop bits.
- Back-to-back frames: with valid held high, the handshake happens in the first IDLE cycle. TX stays high for exactly 1 extra cycle between frames.
- valid=0 in IDLE: TX stays 1 and state is unchanged. tx_data_i is don't-care when valid=0.

Optional Feature:
- Macro: UART_TX_BREAK_EN.
- Enabled: adds input tx_break_i (1 bit).
  - If tx_break_i=1 while in IDLE: FSM enters BREAK. TX=0, busy_o=1, ready=0.
  - tx_break_i=1 during a frame is ignored until the frame ends.
  - On deassertion: TX=1 for one full bit period (DIV of the current cfg_i baud), then IDLE.
- Disabled: no port and no BREAK state. Behaviour is exactly as above.

Test Plan:
- Basic frame: INTERNAL_CLOCK=1e6, cfg=0x33 (9600, 2 stop, no parity, 8 bit), byte 0x11, handshake at cycle 0.
  - DIV=104. TX=0 on cycles 1..104.
  - Data bits 1,0,0,0,1,0,0,0 at 104 cycles each (cycles 105..936).
  - TX=1 on 937..1144. frame_done_o and ready=1 at cycle 1145.
- Even parity: cfg={1,0,2'd2,2'd2} (7 bit, even, 1 stop), byte 0x55.
  - Data 1,0,1,0,1,0,1, then parity 0, then 1 stop bit.
  - 10 bits = 1040 cycles total.
- Odd parity, 5 bit: cfg={1,0,2'd1,2'd0}, byte 0xEE.
  - Data 0,1,1,1,0, parity 0. Bits 5..7 of the byte are not sent.
- Fastest baud: cfg baud=7, DIV=2, byte 0xA5, 8N1.
  - 10-bit frame = 20 cycles.
  - Second byte with valid held high starts after exactly 1 idle-high cycle.
- Config change and reset:
  - Change cfg_i to baud 0 mid-frame: the current frame keeps DIV=104.
  - Drop rst_n at cycle 300: TX=1 immediately. After release, ready=1 and no residual bits are sent.
- Break (UART_TX_BREAK_EN): tx_break_i=1 for 500 cycles in IDLE.
  - TX=0 for 500 cycles, then TX=1 for 104 cycles with ready=0, then ready=1.
